// File: rtl/dmem_initiator.sv
// Data-port initiator for the 32-bit word-addressed memory bus: one load/store in
// flight, converted to a byte-masked word transaction, returning extended data or a fault.
module dmem_initiator #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_fault,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   localparam logic [1:0] F_OK  = 2'b00;
   localparam logic [1:0] F_MIS = 2'b01;
   localparam logic [1:0] F_ILL = 2'b10;
   localparam logic [1:0] F_TMO = 2'b11;

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [3:0]  mask_q;
   logic [31:0] cnt;

   logic        ill, mis;
   logic [3:0]  bmask;
   logic [31:0] rep;
   logic [31:0] sh, ext;
   logic        live, tmo_hit;

   // Command decode: legality, alignment, byte lanes and replicated store data.
   always_comb begin
      case (req_funct3)
         3'b000, 3'b001, 3'b010: ill = 1'b0;
         3'b100, 3'b101:         ill = req_we;
         default:                ill = 1'b1;
      endcase
      mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      case (req_funct3[1:0])
         2'b00: begin
            bmask = 4'b0001 << req_addr[1:0];
            rep   = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            bmask = 4'b0011 << req_addr[1:0];
            rep   = {2{req_wdata[15:0]}};
         end
         default: begin
            bmask = 4'b1111;
            rep   = req_wdata;
         end
      endcase
   end

   always_comb begin
      sh = mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ext = {24'd0, sh[7:0]};
         3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ext = {16'd0, sh[15:0]};
         default: ext = sh;
      endcase
   end

   // Masks drop in the resp cycle so the responder never sees a second request.
   assign live      = (state == WAIT) && !mem_resp;
   assign mem_rmask = (live && !we_q) ? mask_q : 4'b0000;
   assign mem_wmask = (live &&  we_q) ? mask_q : 4'b0000;
   assign req_ready = (state == IDLE);
   assign tmo_hit   = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         mask_q    <= 4'b0000;
         cnt       <= 32'd0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_fault <= F_OK;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (ill || mis) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'd0;
                     rsp_fault <= ill ? F_ILL : F_MIS;
                  end else begin
                     we_q      <= req_we;
                     f3_q      <= req_funct3;
                     off_q     <= req_addr[1:0];
                     mask_q    <= bmask;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= rep;
                     cnt       <= 32'd0;
                     state     <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (mem_resp) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= we_q ? 32'd0 : ext;
                  rsp_fault <= F_OK;
                  state     <= IDLE;
               end else if (tmo_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= 32'd0;
                  rsp_fault <= F_TMO;
                  state     <= DRAIN;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            DRAIN: begin
               // The late answer to the timed-out request is swallowed here.
               if (mem_resp) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_initiator.sv
// Randomized bench for dmem_initiator: byte-level reference memory, latency-controlled
// responder, timeout and reset scenarios on a second TIMEOUT=8 instance.
module tb_dmem_initiator;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_valid, req_ready, req_we, rsp_valid, mem_resp;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  rsp_fault;
   logic [3:0]  mem_rmask, mem_wmask;

   logic        v8, rdy8, rv8, resp8;
   logic [31:0] rd8, addr8, wd8;
   logic [1:0]  f8;
   logic [3:0]  rm8, wm8;

   dmem_initiator dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp));

   dmem_initiator #(.TIMEOUT(8)) dut8 (
      .clk(clk), .rst(rst), .req_valid(v8), .req_ready(rdy8), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv8), .rsp_rdata(rd8), .rsp_fault(f8),
      .mem_addr(addr8), .mem_rmask(rm8), .mem_wmask(wm8),
      .mem_wdata(wd8), .mem_rdata(mem_rdata), .mem_resp(resp8));

   int checks = 0, failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic [7:0]  ref_mem [0:1023];
   logic [31:0] ram [0:255];

   // Reference: byte-granular memory, sign extension by subtraction.
   task automatic ref_model(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd,
                            output logic [1:0] flt, output logic [31:0] rd, output logic [3:0] rm,
                            output logic [3:0] wm, output logic [31:0] mwd);
      int n;
      longint v;
      flt = 2'b00; rd = 0; rm = 0; wm = 0; mwd = 0; v = 0;
      n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
      if (n == 0 || (f3[2] && (we || n == 4))) flt = 2'b10;
      else if (a % n != 0) flt = 2'b01;
      else begin
         for (int i = 0; i < n; i++) begin
            if (we) begin wm[a % 4 + i] = 1'b1; ref_mem[a + i] = wd[8*i +: 8]; end
            else begin rm[a % 4 + i] = 1'b1; v += longint'(ref_mem[a + i]) << (8*i); end
         end
         for (int j = 0; j < 4; j++) mwd[8*j +: 8] = wd[8*(j % n) +: 8];
         if (!we && !f3[2] && n < 4 && ref_mem[a + n - 1][7]) v -= longint'(1) << (8*n);
         rd = we ? 32'd0 : v[31:0];
      end
   endtask

   // Responder for the main instance.
   int  lat = 0;
   bit  rand_lat = 0, silent = 0;
   int  inj_req = 0, inj_ack = 0, resp_mask_err = 0;
   initial begin
      bit busy; int cnt; logic [31:0] ra, rwd; logic [3:0] rwm;
      busy = 0; cnt = 0; ra = 0; rwd = 0; rwm = 0;
      mem_resp = 1'b0; mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (mem_resp) mem_resp = 1'b0;
         else if (rst) busy = 0;
         else if (inj_req != inj_ack) begin
            inj_ack = inj_req; mem_resp = 1'b1; mem_rdata = $urandom;
         end else if (busy) begin
            if (cnt == 0) begin
               busy = 0;
               mem_resp = 1'b1;
               mem_rdata = ram[ra[9:2]];
               for (int j = 0; j < 4; j++) if (rwm[j]) ram[ra[9:2]][8*j +: 8] = rwd[8*j +: 8];
               #1;
               if ((mem_rmask | mem_wmask) != 4'b0000) resp_mask_err++;
            end else cnt--;
         end else if (!silent && (mem_rmask | mem_wmask) != 4'b0000) begin
            busy = 1; cnt = rand_lat ? int'($urandom_range(4, 14)) : lat;
            ra = mem_addr; rwm = mem_wmask; rwd = mem_wdata;
         end
      end
   end

   typedef struct {
      logic [1:0] f; logic [31:0] d; int c; bit seen;
      logic [3:0] rm, wm; logic [31:0] a, wd;
   } rsp_t;
   rsp_t rq[$];
   int   stab_err = 0;

   // Monitor: one record per response, with what the bus showed during that command.
   initial begin
      rsp_t cur;
      cur = '{f: 0, d: 0, c: 0, seen: 0, rm: 0, wm: 0, a: 0, wd: 0};
      forever begin
         @(negedge clk);
         if (rst) cur.seen = 0;
         else begin
            if ((mem_rmask | mem_wmask) != 4'b0000) begin
               if (!cur.seen) begin
                  cur.seen = 1; cur.rm = mem_rmask; cur.wm = mem_wmask;
                  cur.a = mem_addr; cur.wd = mem_wdata;
               end else if ({cur.rm, cur.wm, cur.a, cur.wd} != {mem_rmask, mem_wmask, mem_addr, mem_wdata})
                  stab_err++;
            end
            if (rsp_valid) begin
               cur.f = rsp_fault; cur.d = rsp_rdata; cur.c = cyc;
               rq.push_back(cur);
               cur.seen = 0;
            end
         end
      end
   end

   task automatic run_cmd(input string tag, input logic we, input logic [2:0] f3, input int a,
                          input logic [31:0] wd, input int exp_lat);
      logic [1:0] ef; logic [31:0] ed, ewd; logic [3:0] erm, ewm;
      int n, acc;
      rsp_t r;
      ref_model(we, f3, a, wd, ef, ed, erm, ewm, ewd);
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = 32'(a); req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      acc = cyc + 1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (rq.size() == 0 && n < 200) begin @(negedge clk); n++; end
      if (rq.size() == 0) begin chk({tag, "_no_rsp"}, 0, 1); return; end
      r = rq.pop_front();
      chk({tag, "_fault"}, 32'(r.f), 32'(ef));
      chk({tag, "_rdata"}, r.d, ed);
      if (exp_lat >= 0) chk({tag, "_lat"}, 32'(r.c - acc), 32'(ef != 0 ? 0 : exp_lat));
      if (ef != 0) chk({tag, "_nomask"}, 32'(r.seen), 0);
      else begin
         chk({tag, "_addr"}, r.a, 32'(a) & 32'hFFFF_FFFC);
         chk({tag, "_masks"}, {24'd0, r.rm, r.wm}, {24'd0, erm, ewm});
         if (we) chk({tag, "_wdata"}, r.wd, ewd);
      end
   endtask

   initial begin
      logic [1:0] ef; logic [31:0] ed, ewd; logic [3:0] erm, ewm;
      logic [31:0] w;
      logic [2:0] lf [4];
      int la [4];
      logic [31:0] exp_d [4];
      logic [1:0] exp_f [4];
      int i, g, fm, rc, cntr;
      rsp_t r;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 0; req_wdata = 0; v8 = 1'b0; resp8 = 1'b0;
      for (int k = 0; k < 256; k++) begin
         w = $urandom;
         ram[k] = w;
         for (int b = 0; b < 4; b++) ref_mem[4*k + b] = w[8*b +: 8];
      end
      w = 32'h8BAD_F00D;
      ram[32'h100 >> 2] = w;
      for (int b = 0; b < 4; b++) ref_mem[32'h100 + b] = w[8*b +: 8];

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_fault", 32'(rsp_fault), 0);
      chk("rst_masks", {24'd0, mem_rmask, mem_wmask}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      rst = 1'b0;

      // Directed cases with a zero-wait responder.
      lat = 0;
      run_cmd("lb103", 1'b0, 3'b000, 32'h103, 0, 2);
      run_cmd("lbu103", 1'b0, 3'b100, 32'h103, 0, 2);
      run_cmd("lh100", 1'b0, 3'b001, 32'h100, 0, 2);
      run_cmd("sh102", 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 2);
      run_cmd("lw100", 1'b0, 3'b010, 32'h100, 0, 2);
      chk("lw100_const", ram[32'h100 >> 2], 32'hABCD_F00D);
      run_cmd("lw102_mis", 1'b0, 3'b010, 32'h102, 0, 0);
      run_cmd("sh101_mis", 1'b1, 3'b001, 32'h101, 32'h5555_AAAA, 0);
      run_cmd("sbu_ill", 1'b1, 3'b100, 32'h104, 32'h77, 0);
      run_cmd("f011_ill", 1'b0, 3'b011, 32'h108, 0, 0);

      // Random mix with a fixed per-command latency.
      for (int k = 0; k < 30; k++) begin
         lat = $urandom_range(0, 6);
         run_cmd("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1023)), $urandom, lat + 2);
      end

      // Four back-to-back loads with req_valid held high, random latency.
      rand_lat = 1;
      for (int k = 0; k < 4; k++) begin
         lf[k] = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b100;
         la[k] = (lf[k] == 3'b010) ? int'($urandom_range(0, 255)) * 4 : int'($urandom_range(0, 1023));
         ref_model(1'b0, lf[k], la[k], 0, ef, ed, erm, ewm, ewd);
         exp_d[k] = ed; exp_f[k] = ef;
      end
      @(negedge clk);
      req_we = 1'b0; req_funct3 = lf[0]; req_addr = 32'(la[0]); req_valid = 1'b1;
      i = 0; g = 0;
      while (i < 4 && g < 400) begin
         if (req_ready) begin
            i++;
            @(negedge clk);
            if (i < 4) begin req_funct3 = lf[i]; req_addr = 32'(la[i]); end
            else req_valid = 1'b0;
         end else @(negedge clk);
         g++;
      end
      req_valid = 1'b0;
      g = 0;
      while (rq.size() < 4 && g < 100) begin @(negedge clk); g++; end
      chk("b2b_count", 32'(rq.size()), 4);
      for (int k = 0; k < 4 && rq.size() > 0; k++) begin
         r = rq.pop_front();
         chk("b2b_fault", 32'(r.f), 32'(exp_f[k]));
         chk("b2b_rdata", r.d, exp_d[k]);
      end
      rand_lat = 0;

      // Timeout on the TIMEOUT=8 instance, then a late response in DRAIN.
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; v8 = 1'b1;
      fm = -1; rc = -1;
      for (int k = 0; k < 40 && rc < 0; k++) begin
         @(negedge clk);
         v8 = 1'b0;
         if (rm8 != 4'b0000 && fm < 0) fm = cyc;
         if (rv8) begin rc = cyc; chk("tmo_fault", 32'(f8), 32'(2'b11)); chk("tmo_rdata", rd8, 0); end
      end
      chk("tmo_seen", 32'(rc >= 0 && fm >= 0), 1);
      chk("tmo_delay", 32'(rc - fm), 8);
      cntr = 0;
      repeat (5) begin
         @(negedge clk);
         if (rdy8 || rm8 != 0 || wm8 != 0 || rv8) cntr++;
      end
      chk("drain_quiet", 32'(cntr), 0);
      resp8 = 1'b1;
      @(negedge clk);
      resp8 = 1'b0;
      cntr = 0;
      repeat (6) begin @(negedge clk); if (rv8) cntr++; end
      chk("drain_drop", 32'(cntr), 0);
      chk("drain_ready", 32'(rdy8), 1);

      // Reset in the middle of WAIT, then a stray response.
      silent = 1;
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h201; req_wdata = 32'hA5; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_wait_wmask", {28'd0, mem_wmask}, 32'b0010);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_ready", 32'(req_ready), 1);
      chk("rst2_masks", {24'd0, mem_rmask, mem_wmask}, 0);
      chk("rst2_addr", mem_addr, 0);
      chk("rst2_wdata", mem_wdata, 0);
      chk("rst2_rsp", {30'd0, rsp_valid, 1'b0} | rsp_rdata | 32'(rsp_fault), 0);
      inj_req++;
      repeat (6) @(negedge clk);
      chk("stray_resp", 32'(rq.size()), 0);
      chk("stray_ready", 32'(req_ready), 1);

      chk("wait_stable", 32'(stab_err), 0);
      chk("mask_at_resp", 32'(resp_mask_err), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
